// File: rtl/uart_pkg.sv
// Shared types and constants for the memory-mapped UART transmitter.
//   uart_state_t : serializer FSM states (PARITY exists only when UART_TX_PARITY_EN is built)
//   *_OFS        : register byte offsets from the window base address
//   ST_*         : bit positions inside the STATUS register
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;

    localparam logic [31:0] TXDATA_OFS = 32'd0;
    localparam logic [31:0] STATUS_OFS = 32'd4;

    localparam int unsigned ST_ACTIVE = 0;
    localparam int unsigned ST_EMPTY  = 1;
    localparam int unsigned ST_FULL   = 2;
    localparam int unsigned ST_OVF    = 3;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with a combinational head output.
//   clk, rst : clock, synchronous active-high reset (clears pointers and count)
//   push/din : write din when not full, or when full but popping in the same cycle
//   pop/dout : dout always shows the head entry; pop advances it when not empty
//   full/empty : occupancy flags
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem_q[rd_ptr_q];

    // Pointer and occupancy update; simultaneous push and pop keeps count.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible once counted.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter sitting on the CPU data-memory store bus.
//   clk, rst : clock, synchronous active-high reset (aborts any frame, drops queued bytes)
//   WE, A, WD: store bus shared with dmem; a store to BASE_ADDR+0 queues WD[7:0],
//              a store to BASE_ADDR+4 clears the sticky overflow flag
//   RD       : registered read data, STATUS when A==BASE_ADDR+4 else zero
//   tx       : registered serial line, idle high, 8N1 frames LSB first
//   busy     : FIFO non-empty or serializer not idle
// Build option: define UART_TX_PARITY_EN to insert an even-parity bit before STOP.
module mmio_uart_tx
    import uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h1001_0100,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        WE,
    input  logic [31:0] A,
    input  logic [31:0] WD,
    output logic [31:0] RD,
    output logic        tx,
    output logic        busy
);

    localparam int unsigned BW = $clog2(CLKS_PER_BIT);

    uart_state_t   state_q, state_d;
    logic [BW-1:0] baud_q,  baud_d;
    logic [2:0]    bit_q,   bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q,    tx_d;
    logic          ovf_q,   ovf_d;
    logic [31:0]   rd_q,    rd_d;
`ifdef UART_TX_PARITY_EN
    logic          par_q,   par_d;
`endif

    logic          sel_data;
    logic          sel_status;
    logic          wr_data;
    logic          push_ok;
    logic          pop_c;
    logic          last_tick;
    logic [7:0]    fifo_dout;
    logic          fifo_full;
    logic          fifo_empty;
    logic [31:0]   status_c;
    logic          unused_wd;

    assign unused_wd  = ^WD[31:8];

    // Address decode on the full 32-bit byte address.
    assign sel_data   = (A == BASE_ADDR + TXDATA_OFS);
    assign sel_status = (A == BASE_ADDR + STATUS_OFS);
    assign wr_data    = WE && sel_data;
    // A full FIFO still accepts when the serializer pops in the same cycle.
    assign push_ok    = wr_data && (!fifo_full || pop_c);
    assign last_tick  = (baud_q == BW'(CLKS_PER_BIT - 1));

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_ok),
        .pop   (pop_c),
        .din   (WD[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Serializer next-state; tx_d is the line level for the state being entered.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop_c   = 1'b0;
        tx_d    = 1'b1;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop_c   = 1'b1;
                    shift_d = fifo_dout;
                    state_d = START;
                    baud_d  = '0;
`ifdef UART_TX_PARITY_EN
                    par_d   = ^fifo_dout;
`endif
                end
            end
            START: begin
                if (last_tick) begin
                    state_d = DATA;
                    baud_d  = '0;
                    bit_d   = 3'd0;
                end else begin
                    baud_d  = baud_q + BW'(1);
                end
            end
            DATA: begin
                if (last_tick) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (last_tick) begin
                    state_d = STOP;
                    baud_d  = '0;
                end else begin
                    baud_d  = baud_q + BW'(1);
                end
            end
`endif
            STOP: begin
                if (last_tick) begin
                    state_d = IDLE;
                    baud_d  = '0;
                end else begin
                    baud_d  = baud_q + BW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                baud_d  = '0;
            end
        endcase

        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_d = par_d;
`endif
            default: tx_d = 1'b1;
        endcase
    end

    // Status word and read/overflow bookkeeping, all from pre-edge state.
    always_comb begin
        status_c            = '0;
        status_c[ST_ACTIVE] = (state_q != IDLE);
        status_c[ST_EMPTY]  = fifo_empty;
        status_c[ST_FULL]   = fifo_full;
        status_c[ST_OVF]    = ovf_q;

        rd_d  = sel_status ? status_c : 32'h0;

        ovf_d = ovf_q;
        if (WE && sel_status) begin
            ovf_d = 1'b0;
        end else if (wr_data && !push_ok) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            ovf_q   <= 1'b0;
            rd_q    <= '0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            ovf_q   <= ovf_d;
            rd_q    <= rd_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign RD   = rd_q;
    assign tx   = tx_q;
    assign busy = !fifo_empty || (state_q != IDLE);

endmodule
